// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the hazard controller.
//   - Tuse/Tnew are 2-bit cycle counts, 3 meaning "never needed" / "no result".
//   - md_state_e is the state of the multiply/divide busy tracker.
//   - reg_hazard() decides whether one source operand must wait on one producer.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TIME_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [TIME_W-1:0] TUSE_NEVER = 2'd3;
    localparam logic [TIME_W-1:0] TNEW_NONE  = 2'd3;

    typedef enum logic [0:0] {
        MdIdle = 1'b0,
        MdBusy = 1'b1
    } md_state_e;

    // A producer still in flight blocks a consumer that needs the value sooner than it appears.
    // Register 0 is hardwired and never creates a dependency.
    function automatic logic reg_hazard(
        input logic [REG_W-1:0]  src,
        input logic [TIME_W-1:0] tuse,
        input logic [REG_W-1:0]  dst,
        input logic [TIME_W-1:0] tnew
    );
        return (src != '0) && (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: tracks occupancy of the multiply/divide unit.
//   clk, reset : clock, asynchronous active-high reset
//   start      : an MD operation enters the unit this cycle (ignored while busy)
//   is_div     : qualifies start, 1 selects DIV_CYCLES, else MULT_CYCLES
//   busy       : unit occupied (includes the issuing cycle, combinational)
//   done       : registered one-cycle pulse on the last busy cycle
// MULT_CYCLES and DIV_CYCLES must lie in 1..15.
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [CNT_W-1:0] load_cnt;

    assign load_cnt = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // done_q is raised on the edge that brings cnt to 1, so it lines up with the last busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    if (start) begin
                        state_q <= MdBusy;
                        cnt_q   <= load_cnt;
                        done_q  <= (load_cnt == CNT_W'(1));
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                MdBusy: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MdIdle;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        done_q  <= (cnt_q == CNT_W'(2));
                    end
                end
                default: begin
                    state_q <= MdIdle;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_q == MdBusy) | start;
    assign done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation for D-stage hazards.
//   clk, reset           : clock, asynchronous active-high reset
//   D_rs, D_rt           : source registers of the instruction in D
//   D_TuseRs, D_TuseRt   : cycles until D needs each source (3 = never)
//   D_IsMD               : D instruction touches HI/LO or starts an MD op
//   E_A3/E_Tnew          : destination and result latency of the E instruction
//   M_A3/M_Tnew          : destination and result latency of the M instruction
//   E_MDStart, E_MDIsDiv : E issues mult/multu (IsDiv=0) or div/divu (IsDiv=1)
//   Stall                : freeze PC and D register
//   E_Flush              : insert a bubble into E (equals Stall)
//   MD_Busy, MD_Done     : MD unit occupied / last busy cycle pulse
// Build option: define HAZARD_MD_EN to include MD unit tracking and the MD stall.
// Without it MD_Busy and MD_Done are tied low and Stall covers data hazards only.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  D_rs,
    input  logic [REG_W-1:0]  D_rt,
    input  logic [TIME_W-1:0] D_TuseRs,
    input  logic [TIME_W-1:0] D_TuseRt,
    input  logic              D_IsMD,
    input  logic [REG_W-1:0]  E_A3,
    input  logic [TIME_W-1:0] E_Tnew,
    input  logic [REG_W-1:0]  M_A3,
    input  logic [TIME_W-1:0] M_Tnew,
    input  logic              E_MDStart,
    input  logic              E_MDIsDiv,
    output logic              Stall,
    output logic              E_Flush,
    output logic              MD_Busy,
    output logic              MD_Done
);

    logic stall_rs;
    logic stall_rt;
    logic data_stall;
    logic md_stall;

    assign stall_rs = reg_hazard(D_rs, D_TuseRs, E_A3, E_Tnew) |
                      reg_hazard(D_rs, D_TuseRs, M_A3, M_Tnew);
    assign stall_rt = reg_hazard(D_rt, D_TuseRt, E_A3, E_Tnew) |
                      reg_hazard(D_rt, D_TuseRt, M_A3, M_Tnew);
    assign data_stall = stall_rs | stall_rt;

`ifdef HAZARD_MD_EN
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (E_MDStart),
        .is_div (E_MDIsDiv),
        .busy   (MD_Busy),
        .done   (MD_Done)
    );

    assign md_stall = D_IsMD & MD_Busy;
`else
    // MD tracking is absent; these inputs are kept only so the port list is stable.
    logic unused_md;
    assign unused_md = ^{clk, reset, D_IsMD, E_MDStart, E_MDIsDiv,
                         CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};

    assign MD_Busy  = 1'b0;
    assign MD_Done  = 1'b0;
    assign md_stall = 1'b0;
`endif

    // Done never feeds the stall: an MD op may issue the cycle after Done.
    assign Stall   = data_stall | md_stall;
    assign E_Flush = Stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_TuseRs;
    logic [1:0] D_TuseRt;
    logic       D_IsMD;
    logic [4:0] E_A3;
    logic [1:0] E_Tnew;
    logic [4:0] M_A3;
    logic [1:0] M_Tnew;
    logic       E_MDStart;
    logic       E_MDIsDiv;
    logic       Stall;
    logic       E_Flush;
    logic       MD_Busy;
    logic       MD_Done;

    int n_total;
    int n_bad;

    hazard_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_TuseRs  (D_TuseRs),
        .D_TuseRt  (D_TuseRt),
        .D_IsMD    (D_IsMD),
        .E_A3      (E_A3),
        .E_Tnew    (E_Tnew),
        .M_A3      (M_A3),
        .M_Tnew    (M_Tnew),
        .E_MDStart (E_MDStart),
        .E_MDIsDiv (E_MDIsDiv),
        .Stall     (Stall),
        .E_Flush   (E_Flush),
        .MD_Busy   (MD_Busy),
        .MD_Done   (MD_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one data-hazard vector and check Stall/E_Flush combinationally.
    task automatic data_vec(input string tag,
                            input logic [4:0] rs, input logic [1:0] tuse_rs,
                            input logic [4:0] rt, input logic [1:0] tuse_rt,
                            input logic [4:0] ea3, input logic [1:0] etnew,
                            input logic [4:0] ma3, input logic [1:0] mtnew,
                            input logic exp_stall);
        D_rs = rs; D_TuseRs = tuse_rs; D_rt = rt; D_TuseRt = tuse_rt;
        E_A3 = ea3; E_Tnew = etnew; M_A3 = ma3; M_Tnew = mtnew;
        #1;
        check({tag, "_stall"}, Stall, exp_stall);
        check({tag, "_flush"}, E_Flush, exp_stall);
    endtask

    task automatic clear_data();
        D_rs = '0; D_rt = '0; D_TuseRs = 2'd3; D_TuseRt = 2'd3;
        E_A3 = '0; E_Tnew = '0; M_A3 = '0; M_Tnew = '0;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        reset = 1'b1;
        clear_data();
        D_IsMD = 1'b0;
        E_MDStart = 1'b0;
        E_MDIsDiv = 1'b0;
        #1;
        check("rst_busy", MD_Busy, 1'b0);
        check("rst_done", MD_Done, 1'b0);
        check("rst_stall", Stall, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Data hazards (purely combinational).
        data_vec("e_rs_hit",   5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b1);
        data_vec("e_rs_zero",  5'd0, 2'd0, 5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0);
        data_vec("e_rs_zero0", 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, 5'd0, 2'd0, 1'b0);
        data_vec("m_rt_eq",    5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0);
        data_vec("m_rt_hit",   5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 5'd9, 2'd2, 1'b1);
        data_vec("e_rs_eq",    5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0);
        data_vec("e_rs_other", 5'd5, 2'd0, 5'd0, 2'd3, 5'd6, 2'd2, 5'd0, 2'd0, 1'b0);
        data_vec("e_rt_hit",   5'd0, 2'd3, 5'd31, 2'd0, 5'd31, 2'd2, 5'd0, 2'd0, 1'b1);
        data_vec("never_use",  5'd7, 2'd3, 5'd7, 2'd3, 5'd7, 2'd3, 5'd7, 2'd3, 1'b0);
        data_vec("m_rs_hit",   5'd4, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 5'd4, 2'd2, 1'b1);
        data_vec("m_rt_other", 5'd0, 2'd3, 5'd3, 2'd0, 5'd0, 2'd0, 5'd2, 2'd3, 1'b0);
        clear_data();

`ifdef HAZARD_MD_EN
        // mult at cycle 0, second mult issued the cycle after Done (cycle 6).
        D_IsMD = 1'b1;
        E_MDIsDiv = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            @(posedge clk);
            #1 E_MDStart = (c == 0) || (c == 6);
            @(negedge clk);
            check($sformatf("mul_busy_c%0d", c), MD_Busy, c <= 11);
            check($sformatf("mul_done_c%0d", c), MD_Done, (c == 5) || (c == 11));
            check($sformatf("mul_stall_c%0d", c), Stall, c <= 11);
        end

        // div at cycle 0; a second start at cycle 3 must not reload.
        D_IsMD = 1'b0;
        E_MDIsDiv = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk);
            #1 E_MDStart = (c == 0) || (c == 3);
            @(negedge clk);
            check($sformatf("div_busy_c%0d", c), MD_Busy, c <= 10);
            check($sformatf("div_done_c%0d", c), MD_Done, c == 10);
            check($sformatf("div_nostall_c%0d", c), Stall, 1'b0);
        end

        // Async reset in cycle 4 of a div abandons it without a Done pulse.
        D_IsMD = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk);
            #1 E_MDStart = (c == 0);
            @(negedge clk);
            if (c == 4) begin
                check("pre_rst_busy", MD_Busy, 1'b1);
                #1 reset = 1'b1;
                #1;
                check("async_rst_busy", MD_Busy, 1'b0);
                check("async_rst_done", MD_Done, 1'b0);
                check("async_rst_stall", Stall, 1'b0);
                #1 reset = 1'b0;
            end else if (c > 4) begin
                check($sformatf("post_rst_busy_c%0d", c), MD_Busy, 1'b0);
                check($sformatf("post_rst_done_c%0d", c), MD_Done, 1'b0);
            end
        end
        D_IsMD = 1'b0;
`else
        // MD tracking compiled out: start and D_IsMD have no effect.
        D_IsMD = 1'b1;
        E_MDIsDiv = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk);
            #1 E_MDStart = 1'b1;
            E_MDIsDiv = c[0];
            @(negedge clk);
            check($sformatf("nomd_busy_c%0d", c), MD_Busy, 1'b0);
            check($sformatf("nomd_done_c%0d", c), MD_Done, 1'b0);
            check($sformatf("nomd_stall_c%0d", c), Stall, 1'b0);
        end
        // Data stall still active in this build.
        data_vec("nomd_data", 5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd0, 1'b1);
        E_MDStart = 1'b0;
        D_IsMD = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
